// File: rtl/amer_mul_arbiter.sv
// -----------------------------------------------------------------------------
// amer_mul_arbiter
//
// Two-requester round-robin arbiter and sequencer for one shared approximate
// multiplier with error recovery (AMER). Each requester presents an operand
// pair and a recovery enable on a valid/ready port. At most one operation is
// issued per cycle to a fixed-latency multiplier. A tag pipeline records which
// requester owns each in-flight operation. When the product returns, it is
// written into that requester's response FIFO.
//
// Each requester has a credit counter that counts its in-flight operations
// plus its buffered results. A requester is refused once it holds FD credits.
// A returning product therefore always has a free FIFO slot.
//
// Parameters
//   W    operand width (product is 2*W)
//   LAT  multiplier latency, mul_issue -> valid mul_p, 1..4
//   FD   response FIFO depth and per-requester credit limit, 1..4
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake; ready is the combinational grant
//   reqN_a, reqN_b, reqN_rec   operands and error-recovery enable
//   rspN_valid / rspN_ready    response handshake; valid means the FIFO is not empty
//   rspN_p                     product at the FIFO head (zero while empty)
//   mul_issue                  registered strobe: mul_a/mul_b/mul_rec are valid
//   mul_a, mul_b, mul_rec      registered operation to the multiplier
//   mul_p                      product, sampled LAT cycles after mul_issue
//   busy                       any operation in flight or any result buffered
// -----------------------------------------------------------------------------
module amer_mul_arbiter #(
    parameter int W   = 8,
    parameter int LAT = 2,
    parameter int FD  = 2
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req0_rec,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic           req1_rec,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [2*W-1:0] rsp0_p,

    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [2*W-1:0] rsp1_p,

    output logic           mul_issue,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    output logic           mul_rec,
    input  logic [2*W-1:0] mul_p,

    output logic           busy
);

    localparam int              CW       = $clog2(FD + 1);
    localparam int              PW       = (FD > 1) ? $clog2(FD) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(FD);
    localparam logic [PW-1:0]   PTR_LAST = PW'(FD - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CW-1:0]  r_cnt    [2];    // credits in use: in flight + buffered
    logic           r_ptr;           // requester that wins the next tie
    logic [LAT:0]   r_tag_v;         // tag pipeline valid bits
    logic [LAT:0]   r_tag_id;        // tag pipeline requester ids
    logic [2*W-1:0] r_mem    [2][FD];
    logic [PW-1:0]  r_wr_ptr [2];
    logic [PW-1:0]  r_rd_ptr [2];
    logic [CW-1:0]  r_fill   [2];

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [1:0] w_req_valid;
    logic [1:0] w_rsp_ready;
    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic       w_grant_any;
    logic       w_grant_id;
    logic [1:0] w_rsp_valid;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    // Ring-buffer pointer advance. The explicit wrap also handles a depth that
    // is not a power of two.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a value before any
    // conditional logic runs. A path that leaves a signal unassigned would
    // infer a latch.
    always_comb begin
        w_elig[0]   = w_req_valid[0] && (r_cnt[0] < CNT_MAX);
        w_elig[1]   = w_req_valid[1] && (r_cnt[1] < CNT_MAX);
        w_grant_any = |w_elig;
        // On a tie the pointer decides. Otherwise the only eligible requester wins.
        w_grant_id  = (&w_elig) ? r_ptr : w_elig[1];
        w_grant     = 2'b00;
        if (w_grant_any) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // -------------------------------------------------------------------------
    // Credit counters and round-robin pointer
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments. Every register then
    // updates from values taken before the edge, whatever order the blocks
    // are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
            r_ptr    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                // A pop frees the credit only from the next cycle on. A grant
                // and a pop in the same cycle cancel out.
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (w_grant_any) begin
                r_ptr <= ~w_grant_id;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Issue register: the operation leaves the block one cycle after its grant
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_issue <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_rec   <= 1'b0;
        end else begin
            mul_issue <= w_grant_any;
            if (w_grant_any) begin
                mul_a   <= w_grant_id ? req1_a   : req0_a;
                mul_b   <= w_grant_id ? req1_b   : req0_b;
                mul_rec <= w_grant_id ? req1_rec : req0_rec;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline
    // Stage 0 is loaded on the same edge as mul_issue, so it stays in step with
    // the issued operation. Stage LAT is valid during the cycle in which mul_p
    // carries that operation's product.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v  <= {r_tag_v[LAT-1:0],  w_grant_any};
            r_tag_id <= {r_tag_id[LAT-1:0], w_grant_id};
        end
    end

    // -------------------------------------------------------------------------
    // Response FIFOs (first-word fall-through)
    // -------------------------------------------------------------------------
    always_comb begin
        w_rsp_valid[0] = (r_fill[0] != '0);
        w_rsp_valid[1] = (r_fill[1] != '0);
        w_pop[0]       = w_rsp_valid[0] && w_rsp_ready[0];
        w_pop[1]       = w_rsp_valid[1] && w_rsp_ready[1];
        w_push[0]      = r_tag_v[LAT] && (r_tag_id[LAT] == 1'b0);
        w_push[1]      = r_tag_v[LAT] && (r_tag_id[LAT] == 1'b1);
    end

    // NOTE: the storage array has no reset. Reset clears the fill counts and
    // pointers, so an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= mul_p;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_fill[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= f_next(r_wr_ptr[i]);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= f_next(r_rd_ptr[i]);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_fill[i] <= r_fill[i] + CW'(1);
                    2'b01:   r_fill[i] <= r_fill[i] - CW'(1);
                    default: r_fill[i] <= r_fill[i];
                endcase
            end
        end
    end

    // The head is forced to zero while the FIFO is empty. Stale data is never
    // visible, and the output is zero straight after reset.
    assign rsp0_valid = w_rsp_valid[0];
    assign rsp1_valid = w_rsp_valid[1];
    assign rsp0_p     = w_rsp_valid[0] ? r_mem[0][r_rd_ptr[0]] : '0;
    assign rsp1_p     = w_rsp_valid[1] ? r_mem[1][r_rd_ptr[1]] : '0;

    assign busy = (r_cnt[0] != '0) || (r_cnt[1] != '0);

    // -------------------------------------------------------------------------
    // Invariants of the credit scheme
    // -------------------------------------------------------------------------
    a_no_push_when_full0 : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push[0] && (r_fill[0] == CNT_MAX)));
    a_no_push_when_full1 : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push[1] && (r_fill[1] == CNT_MAX)));
    a_cnt_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        (r_cnt[0] <= CNT_MAX) && (r_cnt[1] <= CNT_MAX));

endmodule
